// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder
// Turns ALU-op requests {ALUControl code, rd, rs1, rs2/imm} into RV32I OP / OP-IMM
// instruction words. Words are queued in a small FIFO and streamed out with
// sequential byte addresses, for use by the boot/test program loader.
module alu_instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctrl,
    input  logic              use_imm,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [11:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W:0]    ptr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] F7_ALT     = 7'h20;

    // FIFO storage and pointers (one extra bit distinguishes full from empty)
    logic [31:0] memQ [DEPTH];
    ptr_t        wrPtrQ, wrPtrD;
    ptr_t        rdPtrQ, rdPtrD;
    addr_t       addrQ, addrD;
    logic        errQ, errD;
    logic [7:0]  errCountQ, errCountD;

    // Decoded request fields
    logic [2:0]  funct3;
    logic        altOp;
    logic        isShift;
    logic        ctrlOk;
    logic        reqLegal;
    logic [6:0]  funct7;
    logic [11:0] immField;
    logic [31:0] instrWord;

    // Handshake / FIFO status
    logic        fifoFull;
    logic        fifoEmpty;
    logic        accept;
    logic        push;
    logic        pop;

    // Map the ALUControl code onto funct3 and note which ops use the alternate funct7
    always_comb begin
        funct3  = 3'd0;
        altOp   = 1'b0;
        isShift = 1'b0;
        ctrlOk  = 1'b1;
        case (alu_ctrl)
            4'd0: funct3 = 3'd0;
            4'd1: begin
                funct3 = 3'd0;
                altOp  = 1'b1;
            end
            4'd2: funct3 = 3'd7;
            4'd3: funct3 = 3'd6;
            4'd4: funct3 = 3'd4;
            4'd5: funct3 = 3'd2;
            4'd6: begin
                funct3  = 3'd1;
                isShift = 1'b1;
            end
            4'd7: begin
                funct3  = 3'd5;
                isShift = 1'b1;
            end
            4'd8: begin
                funct3  = 3'd5;
                isShift = 1'b1;
                altOp   = 1'b1;
            end
            4'd9: funct3 = 3'd3;
            default: ctrlOk = 1'b0;
        endcase
    end

    // Decide legality and assemble the instruction word in R- or I-type layout
    always_comb begin
        reqLegal = ctrlOk;
        if (use_imm && (alu_ctrl == 4'd1)) begin
            reqLegal = 1'b0;
        end
        if (use_imm && isShift && (imm[11:5] != 7'd0)) begin
            reqLegal = 1'b0;
        end
        funct7   = altOp ? F7_ALT : 7'd0;
        immField = isShift ? {funct7, imm[4:0]} : imm;
        if (use_imm) begin
            instrWord = {immField, rs1, funct3, rd, OPC_OP_IMM};
        end else begin
            instrWord = {funct7, rs2, rs1, funct3, rd, OPC_OP};
        end
    end

    assign fifoEmpty = (wrPtrQ == rdPtrQ);
    assign fifoFull  = (wrPtrQ[PTR_W] != rdPtrQ[PTR_W]) &&
                       (wrPtrQ[PTR_W-1:0] == rdPtrQ[PTR_W-1:0]);

    // A reset cycle must never accept, so reset gates in_ready directly
    assign in_ready  = reset && !fifoFull;
    assign accept    = in_valid && in_ready;
    assign push      = accept && reqLegal;
    assign out_valid = !fifoEmpty;
    assign pop       = out_valid && out_ready;

    assign out_instr = fifoEmpty ? 32'd0 : memQ[rdPtrQ[PTR_W-1:0]];
    assign out_addr  = addrQ;
    assign err       = errQ;
    assign err_count = errCountQ;

    // Next-state for pointers, output address and the sticky error bookkeeping
    always_comb begin
        wrPtrD    = wrPtrQ;
        rdPtrD    = rdPtrQ;
        addrD     = addrQ;
        errD      = errQ;
        errCountD = errCountQ;
        if (push) begin
            wrPtrD = wrPtrQ + ptr_t'(1);
        end
        if (pop) begin
            rdPtrD = rdPtrQ + ptr_t'(1);
            addrD  = addrQ + addr_t'(4);
        end
        if (accept && !reqLegal) begin
            errD = 1'b1;
            if (errCountQ != 8'hFF) begin
                errCountD = errCountQ + 8'd1;
            end
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            addrQ     <= BASE_ADDR;
            errQ      <= 1'b0;
            errCountQ <= 8'd0;
        end else begin
            wrPtrQ    <= wrPtrD;
            rdPtrQ    <= rdPtrD;
            addrQ     <= addrD;
            errQ      <= errD;
            errCountQ <= errCountD;
        end
    end

    // FIFO data array; contents need no reset because the empty flag masks them
    always_ff @(posedge clk) begin
        if (push) begin
            memQ[wrPtrQ[PTR_W-1:0]] <= instrWord;
        end
    end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// tb_alu_instr_encoder
// Self-checking bench for alu_instr_encoder: a queue-based model of the encoder
// and its FIFO, a per-cycle compare process, and directed literal checks.
module tb_alu_instr_encoder;

    localparam int DEPTH = 4;
    localparam int ADDR_W = 32;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic        use_imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_count;

    int total;
    int bad;
    bit chkEn;

    logic [31:0] modelQ[$];
    logic [31:0] modelAddr;
    int          modelErr;
    int          modelCnt;

    alu_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .use_imm(use_imm), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden encoder: build the word from field weights (powers of two) using mnemonic tables
    function automatic logic [31:0] goldenEncode(int ctrl, int useImm, int rdV, int rs1V, int rs2V, int immV);
        int f3tab[10];
        int unsigned word;
        int unsigned immPart;
        bit alt;
        bit shift;
        f3tab = '{0, 0, 7, 6, 4, 2, 1, 5, 5, 3};
        alt   = (ctrl == 1) || (ctrl == 8);
        shift = (ctrl >= 6) && (ctrl <= 8);
        word  = rdV * 128 + f3tab[ctrl] * 4096 + rs1V * 32768;
        if (useImm != 0) begin
            immPart = shift ? ((alt ? 1024 : 0) + (immV % 32)) : immV;
            word = word + immPart * 1048576 + 19;
        end else begin
            word = word + rs2V * 1048576 + (alt ? 32'h4000_0000 : 0) + 51;
        end
        return word;
    endfunction

    function automatic bit goldenLegal(int ctrl, int useImm, int immV);
        if (ctrl > 9) return 1'b0;
        if (ctrl == 1 && useImm != 0) return 1'b0;
        if (ctrl >= 6 && ctrl <= 8 && useImm != 0 && (immV / 32) != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(int ctrl, int useImm, int rdV, int rs1V, int rs2V, int immV);
        @(negedge clk);
        #1;
        alu_ctrl = 4'(ctrl);
        use_imm  = useImm[0];
        rd       = 5'(rdV);
        rs1      = 5'(rs1V);
        rs2      = 5'(rs2V);
        imm      = 12'(immV);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // Reference model: observe the handshakes at each rising edge and update the queue
    always @(posedge clk) begin
        int sz;
        bit pushOk;
        if (!reset) begin
            modelQ.delete();
            modelAddr = BASE;
            modelErr  = 0;
            modelCnt  = 0;
        end else begin
            sz = modelQ.size();
            pushOk = in_valid && (sz < DEPTH);
            if (out_ready && sz > 0) begin
                void'(modelQ.pop_front());
                modelAddr = modelAddr + 32'd4;
            end
            if (pushOk) begin
                if (goldenLegal(int'(alu_ctrl), int'(use_imm), int'(imm))) begin
                    modelQ.push_back(goldenEncode(int'(alu_ctrl), int'(use_imm), int'(rd),
                                                  int'(rs1), int'(rs2), int'(imm)));
                end else begin
                    modelErr = 1;
                    if (modelCnt < 255) modelCnt++;
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("in_ready", 32'(in_ready), 32'(reset && (modelQ.size() < DEPTH)));
            checkOutput("out_valid", 32'(out_valid), 32'(modelQ.size() > 0));
            if (modelQ.size() > 0) begin
                checkOutput("out_instr", out_instr, modelQ[0]);
            end
            checkOutput("out_addr", out_addr, modelAddr);
            checkOutput("err", 32'(err), 32'(modelErr));
            checkOutput("err_count", 32'(err_count), 32'(modelCnt));
        end
    end

    initial begin
        int ctrl;
        int ui;
        int iv;
        total = 0;
        bad = 0;
        chkEn = 1'b0;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        alu_ctrl = 4'd0;
        use_imm = 1'b0;
        rd = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        imm = 12'd0;

        // Pin the model itself against hand-encoded words
        checkOutput("pin_add", goldenEncode(0, 0, 1, 2, 3, 0), 32'h003100B3);
        checkOutput("pin_sub", goldenEncode(1, 0, 5, 6, 7, 0), 32'h407302B3);
        checkOutput("pin_addi", goldenEncode(0, 1, 1, 0, 0, 12'hFFF), 32'hFFF00093);
        checkOutput("pin_srai", goldenEncode(8, 1, 4, 4, 0, 3), 32'h40325213);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_addr", out_addr, BASE);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        chkEn = 1'b1;
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD x1,x2,x3 appears one cycle after acceptance
        out_ready = 1'b1;
        applyStimulus(0, 0, 1, 2, 3, 0);
        @(negedge clk);
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_instr", out_instr, 32'h003100B3);
        checkOutput("add_addr", out_addr, 32'h0);

        // SUB then ADDI held while out_ready is low
        doReset();
        out_ready = 1'b0;
        applyStimulus(1, 0, 5, 6, 7, 0);
        applyStimulus(0, 1, 1, 0, 0, 12'hFFF);
        @(negedge clk);
        checkOutput("sub_instr", out_instr, 32'h407302B3);
        checkOutput("sub_addr", out_addr, 32'h0);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("addi_instr", out_instr, 32'hFFF00093);
        checkOutput("addi_addr", out_addr, 32'h4);
        #1 out_ready = 1'b1;

        // SRAI encoding and the three kinds of illegal request
        applyStimulus(8, 1, 4, 4, 0, 3);
        @(negedge clk);
        checkOutput("srai_instr", out_instr, 32'h40325213);
        checkOutput("srai_err", 32'(err), 32'd0);
        applyStimulus(1, 1, 2, 3, 0, 5);
        @(negedge clk);
        checkOutput("subi_err", 32'(err), 32'd1);
        checkOutput("subi_count", 32'(err_count), 32'd1);
        checkOutput("subi_dropped", 32'(out_valid), 32'd0);
        applyStimulus(12, 0, 1, 1, 1, 0);
        applyStimulus(6, 1, 1, 1, 0, 12'h020);
        @(negedge clk);
        checkOutput("illegal_count", 32'(err_count), 32'd3);

        // Fill to DEPTH with the consumer stalled, then drain in order
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, i + 1, 2, 3, 0);
        end
        @(negedge clk);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_head_addr", out_addr, 32'h0);
        applyStimulus(4, 0, 9, 9, 9, 0);
        @(negedge clk);
        #1 out_ready = 1'b1;
        repeat (DEPTH + 1) @(negedge clk);
        checkOutput("drain_empty", 32'(out_valid), 32'd0);
        checkOutput("drain_addr", out_addr, 32'h10);

        // Continuous push+pop of random legal ops
        for (int i = 0; i < 100; i++) begin
            ctrl = $urandom_range(0, 9);
            ui = (ctrl == 1) ? 0 : $urandom_range(0, 1);
            iv = $urandom_range(0, 4095);
            if (ctrl >= 6 && ctrl <= 8 && ui == 1) iv = iv % 32;
            applyStimulus(ctrl, ui, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), iv);
        end

        // Random back-pressure mixed with occasional illegal requests
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4095));
        end
        out_ready = 1'b1;

        // err_count saturation
        for (int i = 0; i < 260; i++) begin
            applyStimulus(15, 0, 1, 1, 1, 0);
        end
        @(negedge clk);
        checkOutput("sat_count", 32'(err_count), 32'd255);

        // Reset with three words buffered and err set
        doReset();
        out_ready = 1'b0;
        applyStimulus(2, 0, 1, 2, 3, 0);
        applyStimulus(3, 1, 4, 5, 0, 12'h123);
        applyStimulus(9, 0, 6, 7, 8, 0);
        applyStimulus(13, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("pre_rst_err", 32'(err), 32'd1);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_addr", out_addr, BASE);
        checkOutput("mid_rst_err", 32'(err), 32'd0);
        checkOutput("mid_rst_count", 32'(err_count), 32'd0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
